// File: rtl/card_pixel_pipe_pkg.sv
// Shared card definitions: card_type encoding, RGB444 colour type and default geometry.
// Also used by the board/hand layout engine.
package card_pkg;

   localparam int CARD_W_DEF         = 32;
   localparam int CARD_H_DEF         = 46;
   localparam int NUM_SUITS_DEF      = 4;
   localparam int CARDS_PER_SUIT_DEF = 13;
   localparam int NUM_JOKERS_DEF     = 2;

   // Number cards occupy 0..N_NUMBER-1; the jokers follow immediately.
   localparam int N_NUMBER = NUM_SUITS_DEF * CARDS_PER_SUIT_DEF;
   localparam int JOKER_0  = N_NUMBER;
   localparam int JOKER_1  = N_NUMBER + 1;

   typedef logic [11:0] rgb444_t;

   localparam rgb444_t HL_COLOR_DEF  = 12'hFF0;
   localparam rgb444_t BACK_A_DEF    = 12'h00F;
   localparam rgb444_t BACK_B_DEF    = 12'hFFF;
   localparam rgb444_t KEY_COLOR_DEF = 12'hF0F;

   typedef struct packed {
      logic       valid;
      logic [5:0] x;
      logic [5:0] y;
      logic [2:0] sel;
      logic       invalid;
      logic       oob;
      logic       highlight;
      logic       face_down;
   } pix_ctl_t;

endpackage

// File: rtl/card_pixel_pipe_if.sv
// Request, glyph-ROM and result signals of card_pixel_pipe.
// The slave side is the pipe; the master side is the layout engine, the ROMs and the colour mux.
interface card_pixel_pipe_if #(
   parameter int ADDR_W    = 15,
   parameter int NUM_BANKS = 6
);
   logic                    in_valid;
   logic [5:0]              pixel_x;
   logic [5:0]              pixel_y;
   logic [5:0]              card_type;
   logic                    face_down;
   logic                    highlight;
   logic [ADDR_W-1:0]       rom_addr;
   logic [2:0]              rom_sel;
   logic [12*NUM_BANKS-1:0] rom_data;
   logic                    out_valid;
   logic [11:0]             card_pixel;
   logic                    out_transparent;

   modport master (
      output in_valid, pixel_x, pixel_y, card_type, face_down, highlight, rom_data,
      input  rom_addr, rom_sel, out_valid, card_pixel, out_transparent
   );

   modport slave (
      input  in_valid, pixel_x, pixel_y, card_type, face_down, highlight, rom_data,
      output rom_addr, rom_sel, out_valid, card_pixel, out_transparent
   );
endinterface

// File: rtl/card_addr_decode.sv
// S0 decodes card_type into bank/base and flags; S1 forms the registered glyph ROM address.
module card_addr_decode
   import card_pkg::*;
#(
   parameter int CARD_W         = CARD_W_DEF,
   parameter int CARD_H         = CARD_H_DEF,
   parameter int NUM_SUITS      = NUM_SUITS_DEF,
   parameter int CARDS_PER_SUIT = CARDS_PER_SUIT_DEF,
   parameter int NUM_JOKERS     = NUM_JOKERS_DEF,
   parameter int ADDR_W         = 15
) (
   input  logic              clk_25MHz,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [5:0]        pixel_x,
   input  logic [5:0]        pixel_y,
   input  logic [5:0]        card_type,
   input  logic              face_down,
   input  logic              highlight,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [2:0]        rom_sel,
   output pix_ctl_t          s1_ctl
);
   localparam int         AW2 = ADDR_W + 2;
   localparam int         N   = NUM_SUITS * CARDS_PER_SUIT;
   localparam logic [6:0] N7  = 7'(N);
   localparam logic [6:0] NJ7 = 7'(N + NUM_JOKERS);

   if (CARDS_PER_SUIT * CARD_W * CARD_H > (1 << ADDR_W)) begin : g_addr_w_check
      $error("ADDR_W too narrow for the last rank glyph");
   end

   pix_ctl_t          s0_ctl_d, s0_ctl_q, s1_ctl_d, s1_ctl_q;
   logic [AW2-1:0]    base_d, base_q;
   logic [5:0]        rank;
   logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
   logic [2:0]        rom_sel_d, rom_sel_q;

   always_comb begin
      // NOTE: every combinationally written signal gets a default first so no path infers a latch.
      s0_ctl_d           = '0;
      base_d             = '0;
      rank               = '0;
      s0_ctl_d.valid     = in_valid;
      s0_ctl_d.x         = pixel_x;
      s0_ctl_d.y         = pixel_y;
      s0_ctl_d.face_down = face_down;
      s0_ctl_d.highlight = highlight;
      s0_ctl_d.oob       = ({1'b0, pixel_x} >= 7'(CARD_W)) || ({1'b0, pixel_y} >= 7'(CARD_H));
      if ({1'b0, card_type} < N7) begin
         // Divide/modulo by a constant as a compare chain: last suit whose first index is <= card_type.
         for (int s = 0; s < NUM_SUITS; s++) begin
            if (card_type >= 6'(s * CARDS_PER_SUIT)) begin
               s0_ctl_d.sel = 3'(s);
               rank         = card_type - 6'(s * CARDS_PER_SUIT);
            end
         end
         base_d = AW2'(rank) * AW2'(CARD_W * CARD_H);
      end else if ({1'b0, card_type} < NJ7) begin
         s0_ctl_d.sel = 3'(NUM_SUITS) + 3'(card_type - 6'(N));
      end else begin
         s0_ctl_d.invalid = 1'b1;
      end
   end

   always_comb begin
      s1_ctl_d   = s0_ctl_q;
      rom_addr_d = '0;
      rom_sel_d  = '0;
      if (!(s0_ctl_q.invalid || s0_ctl_q.oob)) begin
         rom_addr_d = ADDR_W'(base_q + AW2'(s0_ctl_q.y) * AW2'(CARD_W) + AW2'(s0_ctl_q.x));
         rom_sel_d  = s0_ctl_q.sel;
      end
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         s0_ctl_q   <= '0;
         base_q     <= '0;
         s1_ctl_q   <= '0;
         rom_addr_q <= '0;
         rom_sel_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
         s0_ctl_q   <= s0_ctl_d;
         base_q     <= base_d;
         s1_ctl_q   <= s1_ctl_d;
         rom_addr_q <= rom_addr_d;
         rom_sel_q  <= rom_sel_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign rom_sel  = rom_sel_q;
   assign s1_ctl   = s1_ctl_q;

endmodule

// File: rtl/card_pixel_pipe.sv
// Pipelined card pixel lookup: address decode, ROM-aligned delay line and output colour rules.
module card_pixel_pipe
   import card_pkg::*;
#(
   parameter int      CARD_W         = CARD_W_DEF,
   parameter int      CARD_H         = CARD_H_DEF,
   parameter int      NUM_SUITS      = NUM_SUITS_DEF,
   parameter int      CARDS_PER_SUIT = CARDS_PER_SUIT_DEF,
   parameter int      NUM_JOKERS     = NUM_JOKERS_DEF,
   parameter int      ADDR_W         = 15,
   parameter int      ROM_LAT        = 1,
   parameter int      BORDER         = 2,
   parameter rgb444_t HL_COLOR       = HL_COLOR_DEF,
   parameter rgb444_t BACK_A         = BACK_A_DEF,
   parameter rgb444_t BACK_B         = BACK_B_DEF,
   parameter rgb444_t KEY_COLOR      = KEY_COLOR_DEF
) (
   input logic               clk_25MHz,
   input logic               rst_n,
   card_pixel_pipe_if.slave  bus
);
   localparam int NUM_BANKS = NUM_SUITS + NUM_JOKERS;

   if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_rom_lat_check
      $error("ROM_LAT must be 1..3");
   end

   pix_ctl_t s1_ctl, ctl;
   pix_ctl_t dly_d [ROM_LAT];
   pix_ctl_t dly_q [ROM_LAT];
   rgb444_t  bank_pix, card_pixel_d, card_pixel_q;
   logic     in_border, out_valid_d, out_valid_q, transp_d, transp_q;

   card_addr_decode #(
      .CARD_W         (CARD_W),
      .CARD_H         (CARD_H),
      .NUM_SUITS      (NUM_SUITS),
      .CARDS_PER_SUIT (CARDS_PER_SUIT),
      .NUM_JOKERS     (NUM_JOKERS),
      .ADDR_W         (ADDR_W)
   ) u_decode (
      .clk_25MHz (clk_25MHz),
      .rst_n     (rst_n),
      .in_valid  (bus.in_valid),
      .pixel_x   (bus.pixel_x),
      .pixel_y   (bus.pixel_y),
      .card_type (bus.card_type),
      .face_down (bus.face_down),
      .highlight (bus.highlight),
      .rom_addr  (bus.rom_addr),
      .rom_sel   (bus.rom_sel),
      .s1_ctl    (s1_ctl)
   );

   always_comb begin
      dly_d[0] = s1_ctl;
      for (int i = 1; i < ROM_LAT; i++) dly_d[i] = dly_q[i-1];
   end

   // NOTE: the delay line is a handful of control flops, not a RAM, so it is reset to flush in-flight valids.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROM_LAT; i++) dly_q[i] <= '0;
      end else begin
         for (int i = 0; i < ROM_LAT; i++) dly_q[i] <= dly_d[i];
      end
   end

   // The last delay stage lines up with the ROM word read for the same request.
   assign ctl       = dly_q[ROM_LAT-1];
   assign in_border = ({1'b0, ctl.x} < 7'(BORDER)) || ({1'b0, ctl.x} >= 7'(CARD_W - BORDER)) ||
                      ({1'b0, ctl.y} < 7'(BORDER)) || ({1'b0, ctl.y} >= 7'(CARD_H - BORDER));

   always_comb begin
      bank_pix = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (ctl.sel == 3'(b)) bank_pix = bus.rom_data[12*b +: 12];
      end
      out_valid_d  = ctl.valid;
      card_pixel_d = '0;
      transp_d     = 1'b0;
      if (ctl.invalid || ctl.oob) begin
         transp_d = 1'b1;
      end else if (ctl.highlight && in_border) begin
         card_pixel_d = HL_COLOR;
      end else if (ctl.face_down) begin
         card_pixel_d = (ctl.x[2] ^ ctl.y[2]) ? BACK_B : BACK_A;
      end else if (bank_pix == KEY_COLOR) begin
         transp_d = 1'b1;
      end else begin
         card_pixel_d = bank_pix;
      end
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         card_pixel_q <= '0;
         transp_q     <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         card_pixel_q <= card_pixel_d;
         transp_q     <= transp_d;
      end
   end

   assign bus.out_valid       = out_valid_q;
   assign bus.card_pixel      = card_pixel_q;
   assign bus.out_transparent = transp_q;

endmodule

// File: tb/tb_card_pixel_pipe.sv
// Bench for card_pixel_pipe at ROM_LAT=1 and ROM_LAT=2 side by side, with behavioural glyph ROMs.
// Directed table vectors check exact timing; a scoreboard checks random streams and reset flushing.
module tb_card_pixel_pipe;
   import card_pkg::*;

   localparam int NB = 6;

   logic clk_25MHz = 1'b0;
   logic rst_n     = 1'b0;
   always #20 clk_25MHz = ~clk_25MHz;

   card_pixel_pipe_if #(.ADDR_W(15), .NUM_BANKS(NB)) bus1 ();
   card_pixel_pipe_if #(.ADDR_W(15), .NUM_BANKS(NB)) bus2 ();

   card_pixel_pipe #(.ROM_LAT(1)) dut1 (.clk_25MHz(clk_25MHz), .rst_n(rst_n), .bus(bus1));
   card_pixel_pipe #(.ROM_LAT(2)) dut2 (.clk_25MHz(clk_25MHz), .rst_n(rst_n), .bus(bus2));

   typedef logic [12:0] res_t;  // {transparent, pixel}

   typedef struct {
      logic [5:0]  ct, x, y;
      logic        fd, hl;
      logic        chk_addr;
      logic [14:0] addr;
      logic [2:0]  sel;
      logic [11:0] pix;
      logic        tr;
   } vec_t;

   vec_t vecs [14];
   res_t q1 [$];
   res_t q2 [$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   sb_en = 1'b0;

   function automatic logic [11:0] rom_val(int bank, logic [14:0] a);
      if (a == 15'd100) return 12'hF0F;
      if (a == 15'd101) return 12'hF0E;
      return 12'((int'(a) * 7 + bank * 409 + 3) % 4096);
   endfunction

   function automatic logic [NB*12-1:0] rom_word(logic [14:0] a);
      logic [NB*12-1:0] w;
      for (int b = 0; b < NB; b++) w[12*b +: 12] = rom_val(b, a);
      return w;
   endfunction

   logic [NB*12-1:0] rom1_q  = '0;
   logic [NB*12-1:0] rom2_q0 = '0;
   logic [NB*12-1:0] rom2_q1 = '0;
   always_ff @(posedge clk_25MHz) begin
      rom1_q  <= rom_word(bus1.rom_addr);
      rom2_q0 <= rom_word(bus2.rom_addr);
      rom2_q1 <= rom2_q0;
   end
   assign bus1.rom_data = rom1_q;
   assign bus2.rom_data = rom2_q1;

   function automatic res_t model(logic [5:0] ct, logic [5:0] x, logic [5:0] y, logic fd, logic hl);
      int ict = int'(ct);
      int ix  = int'(x);
      int iy  = int'(y);
      int sel, addr;
      logic [11:0] p;
      if (ict >= 54 || ix >= 32 || iy >= 46) return {1'b1, 12'h000};
      if (hl && (ix < 2 || ix >= 30 || iy < 2 || iy >= 44)) return {1'b0, 12'hFF0};
      if (fd) return {1'b0, (x[2] ^ y[2]) ? 12'hFFF : 12'h00F};
      if (ict < 52) begin
         sel  = ict / 13;
         addr = (ict % 13) * 32 * 46 + iy * 32 + ix;
      end else begin
         sel  = 4 + ict - 52;
         addr = iy * 32 + ix;
      end
      p = rom_val(sel, 15'(addr));
      if (p == 12'hF0F) return {1'b1, 12'h000};
      return {1'b0, p};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic v, logic [5:0] ct, logic [5:0] x, logic [5:0] y, logic fd, logic hl);
      bus1.in_valid = v; bus1.card_type = ct; bus1.pixel_x = x; bus1.pixel_y = y;
      bus1.face_down = fd; bus1.highlight = hl;
      bus2.in_valid = v; bus2.card_type = ct; bus2.pixel_x = x; bus2.pixel_y = y;
      bus2.face_down = fd; bus2.highlight = hl;
      if (v && sb_en) begin
         q1.push_back(model(ct, x, y, fd, hl));
         q2.push_back(model(ct, x, y, fd, hl));
      end
   endtask

   always @(negedge clk_25MHz) begin
      if (sb_en && bus1.out_valid) begin
         if (q1.size() == 0) check("sb1_unexpected_out", 32'(bus1.card_pixel), 32'hFFFF_FFFF);
         else check("sb1_result", 32'({bus1.out_transparent, bus1.card_pixel}), 32'(q1.pop_front()));
      end
      if (sb_en && bus2.out_valid) begin
         if (q2.size() == 0) check("sb2_unexpected_out", 32'(bus2.card_pixel), 32'hFFFF_FFFF);
         else check("sb2_result", 32'({bus2.out_transparent, bus2.card_pixel}), 32'(q2.pop_front()));
      end
   end

   // One isolated request; bounded wait for each pipe's output and its latency.
   task automatic apply_vec(int i);
      vec_t v = vecs[i];
      int   lat1 = -1;
      int   lat2 = -1;
      res_t r1 = '0;
      res_t r2 = '0;
      @(posedge clk_25MHz); #1;
      drive(1'b1, v.ct, v.x, v.y, v.fd, v.hl);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk_25MHz);
         if (k == 1) begin
            #1 drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
         end
         @(negedge clk_25MHz);
         if (k == 2 && v.chk_addr) begin
            check($sformatf("v%0d_rom_addr", i), 32'(bus1.rom_addr), 32'(v.addr));
            check($sformatf("v%0d_rom_sel", i), 32'(bus1.rom_sel), 32'(v.sel));
         end
         if (bus1.out_valid && lat1 < 0) begin
            lat1 = k - 1;
            r1   = {bus1.out_transparent, bus1.card_pixel};
         end
         if (bus2.out_valid && lat2 < 0) begin
            lat2 = k - 1;
            r2   = {bus2.out_transparent, bus2.card_pixel};
         end
      end
      check($sformatf("v%0d_latency_lat1", i), 32'(lat1), 32'd3);
      check($sformatf("v%0d_latency_lat2", i), 32'(lat2), 32'd4);
      check($sformatf("v%0d_result_lat1", i), 32'(r1), 32'({v.tr, v.pix}));
      check($sformatf("v%0d_result_lat2", i), 32'(r2), 32'({v.tr, v.pix}));
   endtask

   function automatic vec_t mk(logic [5:0] ct, logic [5:0] x, logic [5:0] y, logic fd, logic hl,
                               logic chk, logic [14:0] addr, logic [2:0] sel,
                               logic [11:0] pix, logic tr);
      vec_t v;
      v.ct = ct; v.x = x; v.y = y; v.fd = fd; v.hl = hl;
      v.chk_addr = chk; v.addr = addr; v.sel = sel; v.pix = pix; v.tr = tr;
      return v;
   endfunction

   initial begin
      int sent = 0;
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk_25MHz);
      @(negedge clk_25MHz);
      check("reset_out_valid", 32'({bus1.out_valid, bus2.out_valid}), 32'd0);
      check("reset_card_pixel", 32'(bus1.card_pixel), 32'd0);
      check("reset_transparent", 32'(bus1.out_transparent), 32'd0);
      check("reset_rom_addr", 32'(bus1.rom_addr), 32'd0);
      check("reset_rom_sel", 32'(bus1.rom_sel), 32'd0);
      rst_n = 1'b1;

      //            ct  x   y  fd hl chk addr    sel pixel                  tr
      vecs[0]  = mk(14, 3,  2, 0, 0, 1, 15'd1539, 1, rom_val(1, 15'd1539), 0);
      vecs[1]  = mk(52, 5,  1, 0, 0, 1, 15'd37,   4, rom_val(4, 15'd37),   0);
      vecs[2]  = mk(60, 3,  2, 0, 0, 1, 15'd0,    0, 12'h000,              1);
      vecs[3]  = mk(14, 40, 2, 0, 0, 1, 15'd0,    0, 12'h000,              1);
      vecs[4]  = mk(0,  0, 20, 0, 1, 1, 15'd640,  0, 12'hFF0,              0);
      vecs[5]  = mk(0,  4,  0, 1, 0, 0, 15'd0,    0, 12'hFFF,              0);
      vecs[6]  = mk(0,  0,  0, 1, 0, 0, 15'd0,    0, 12'h00F,              0);
      vecs[7]  = mk(0, 31, 10, 1, 1, 0, 15'd0,    0, 12'hFF0,              0);
      vecs[8]  = mk(0,  4,  3, 0, 0, 1, 15'd100,  0, 12'h000,              1);
      vecs[9]  = mk(0,  5,  3, 0, 0, 1, 15'd101,  0, 12'hF0E,              0);
      vecs[10] = mk(53, 31, 45, 0, 0, 1, 15'd1471, 5, rom_val(5, 15'd1471), 0);
      vecs[11] = mk(51, 31, 45, 0, 0, 1, 15'd19135, 3, rom_val(3, 15'd19135), 0);
      vecs[12] = mk(0,  0, 46, 0, 0, 1, 15'd0,    0, 12'h000,              1);
      vecs[13] = mk(0,  2,  2, 0, 1, 1, 15'd66,   0, rom_val(0, 15'd66),   0);

      for (int i = 0; i < 14; i++) apply_vec(i);

      // Random back-to-back stream with bubbles, checked in order by the scoreboard.
      sb_en = 1'b1;
      while (sent < 100) begin
         @(posedge clk_25MHz); #1;
         if ($urandom_range(0, 3) == 0) begin
            drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
         end else begin
            drive(1'b1, 6'($urandom_range(0, 55)), 6'($urandom_range(0, 33)),
                  6'($urandom_range(0, 47)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            sent++;
         end
      end
      @(posedge clk_25MHz); #1 drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      repeat (10) @(posedge clk_25MHz);
      @(negedge clk_25MHz);
      check("stream_drained_lat1", 32'(q1.size()), 32'd0);
      check("stream_drained_lat2", 32'(q2.size()), 32'd0);

      // Reset with three requests in flight: nothing stale may emerge afterwards.
      sb_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_25MHz); #1 drive(1'b1, 6'(14 + i), 6'(3), 6'(2), 1'b0, 1'b0);
      end
      @(posedge clk_25MHz); #1 drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_out_valid", 32'({bus1.out_valid, bus2.out_valid}), 32'd0);
      check("midreset_rom_addr", 32'(bus1.rom_addr), 32'd0);
      check("midreset_card_pixel", 32'(bus1.card_pixel), 32'd0);
      q1.delete();
      q2.delete();
      sb_en = 1'b1;
      repeat (2) @(negedge clk_25MHz);
      rst_n = 1'b1;
      repeat (8) @(posedge clk_25MHz);
      #1 drive(1'b1, 6'd14, 6'd3, 6'd2, 1'b0, 1'b0);
      @(posedge clk_25MHz); #1 drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      repeat (8) @(posedge clk_25MHz);
      @(negedge clk_25MHz);
      check("postreset_drained_lat1", 32'(q1.size()), 32'd0);
      check("postreset_drained_lat2", 32'(q2.size()), 32'd0);
      sb_en = 1'b0;
      apply_vec(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
